mc_controller: RTL and testbench

MC_CONTROLLER -- requirements
Module: mc_controller

---
 rtl/mc_pkg.sv | 47 ++++
 rtl/mc_wait_timer.sv | 36 +++
 rtl/mc_controller.sv | 201 ++++++++++++++++++++
 tb/tb_mc_controller.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle controller.
// ILLEGAL_TRAP_EN adds the sticky TRAP state to the state enum.
package mc_pkg;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExec,
    StMem,
`ifdef ILLEGAL_TRAP_EN
    StWb,
    StTrap
`else
    StWb
`endif
  } state_e;

  localparam logic [6:0] OpRType  = 7'b0110011;
  localparam logic [6:0] OpIAlu   = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;

  localparam logic [1:0] AluAdd   = 2'b00;
  localparam logic [1:0] AluSub   = 2'b01;
  localparam logic [1:0] AluFunct = 2'b10;

  localparam logic [1:0] PcPlus4   = 2'b00;
  localparam logic [1:0] PcPlusImm = 2'b01;
  localparam logic [1:0] PcAluOut  = 2'b10;

  localparam logic [1:0] SrcBRd2  = 2'b00;
  localparam logic [1:0] SrcBImm  = 2'b01;
  localparam logic [1:0] SrcBFour = 2'b10;

  function automatic logic is_known_op(input logic [6:0] op);
    logic known;
    case (op)
      OpRType, OpIAlu, OpLoad, OpStore, OpBranch, OpJal, OpJalr: known = 1'b1;
      default: known = 1'b0;
    endcase
    return known;
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory wait counter: counts stalled cycles and flags the last allowed one.
module mc_wait_timer #(
  parameter int unsigned Timeout = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam int unsigned CntW = (Timeout > 1) ? $clog2(Timeout) : 1;
  localparam logic [CntW-1:0] Last = CntW'(Timeout - 1);

  logic [CntW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (tick) begin
      count_d = count_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == Last);

endmodule

// File: rtl/mc_controller.sv
// Multicycle CPU control FSM with bounded memory waits.
// Define ILLEGAL_TRAP_EN to trap (sticky until reset) on unrecognised opcodes.
module mc_controller #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       mem_to_reg,
  output logic       link,
  output logic [1:0] pc_src,
  output logic       retire,
  output logic       mem_err
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic       trap
`endif
);

  import mc_pkg::*;

  state_e state_q, state_d;

  logic wait_st;
  logic expired;
  logic timeout;
  logic timer_tick;
  logic timer_clear;

  // Counter only runs while stalled in a memory wait; any other cycle re-arms it.
  assign wait_st     = (state_q == StFetch) || (state_q == StMem);
  assign timeout     = wait_st && expired && !mem_ready;
  assign timer_tick  = wait_st && !mem_ready && !expired;
  assign timer_clear = !timer_tick;

  mc_wait_timer #(
    .Timeout (MEM_TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear),
    .tick    (timer_tick),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch: begin
        if (mem_ready) begin
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (is_known_op(opcode)) begin
          state_d = StExec;
        end else begin
`ifdef ILLEGAL_TRAP_EN
          state_d = StTrap;
`else
          state_d = StFetch;
`endif
        end
      end
      StExec: begin
        case (opcode)
          OpRType, OpIAlu: state_d = StWb;
          OpLoad, OpStore: state_d = StMem;
          default:         state_d = StFetch;
        endcase
      end
      StMem: begin
        if (mem_ready) begin
          state_d = (opcode == OpLoad) ? StWb : StFetch;
        end else if (timeout) begin
          state_d = StFetch;
        end
      end
      StWb: state_d = StFetch;
`ifdef ILLEGAL_TRAP_EN
      StTrap: state_d = StTrap;
`endif
      default: state_d = StFetch;
    endcase
  end

  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SrcBRd2;
    alu_op     = AluAdd;
    mem_to_reg = 1'b0;
    link       = 1'b0;
    pc_src     = PcPlus4;
    retire     = 1'b0;
    mem_err    = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    trap       = 1'b0;
`endif
    // Reset masks everything, so an abandoned access can never write or retire.
    if (!reset) begin
      unique case (state_q)
        StFetch: begin
          mem_read  = 1'b1;
          alu_src_a = 1'b1;
          alu_src_b = SrcBFour;
          alu_op    = AluAdd;
          pc_src    = PcPlus4;
          pc_write  = mem_ready;
          ir_write  = mem_ready;
          mem_err   = timeout;
        end
        StDecode: begin
`ifndef ILLEGAL_TRAP_EN
          retire = !is_known_op(opcode);
`endif
        end
        StExec: begin
          case (opcode)
            OpRType: begin
              alu_op    = AluFunct;
              alu_src_b = SrcBRd2;
            end
            OpIAlu: begin
              alu_op    = AluFunct;
              alu_src_b = SrcBImm;
            end
            OpLoad, OpStore: begin
              alu_op    = AluAdd;
              alu_src_b = SrcBImm;
            end
            OpBranch: begin
              alu_op   = AluSub;
              pc_write = zero;
              pc_src   = PcPlusImm;
              retire   = 1'b1;
            end
            OpJal: begin
              reg_write = 1'b1;
              link      = 1'b1;
              pc_write  = 1'b1;
              pc_src    = PcPlusImm;
              retire    = 1'b1;
            end
            OpJalr: begin
              alu_op    = AluAdd;
              alu_src_b = SrcBImm;
              pc_write  = 1'b1;
              pc_src    = PcAluOut;
              reg_write = 1'b1;
              link      = 1'b1;
              retire    = 1'b1;
            end
            default: ;
          endcase
        end
        StMem: begin
          if (opcode == OpStore) begin
            mem_write = 1'b1;
            retire    = mem_ready;
          end else begin
            mem_read = 1'b1;
          end
          mem_err = timeout;
        end
        StWb: begin
          reg_write  = 1'b1;
          mem_to_reg = (opcode == OpLoad);
          retire     = 1'b1;
        end
`ifdef ILLEGAL_TRAP_EN
        StTrap: trap = 1'b1;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller; output bits are packed into one vector per cycle.
module tb_mc_controller;

  localparam logic [6:0] OpR     = 7'b0110011;
  localparam logic [6:0] OpI     = 7'b0010011;
  localparam logic [6:0] OpLd    = 7'b0000011;
  localparam logic [6:0] OpSt    = 7'b0100011;
  localparam logic [6:0] OpBr    = 7'b1100011;
  localparam logic [6:0] OpJl    = 7'b1101111;
  localparam logic [6:0] OpJr    = 7'b1100111;
  localparam logic [6:0] OpBad   = 7'b0000000;

  // {pc_write, ir_write, mem_read, mem_write, reg_write, alu_src_a, alu_src_b[1:0],
  //  alu_op[1:0], mem_to_reg, link, pc_src[1:0], retire, mem_err}
  localparam logic [15:0] Idle      = 16'h0000;
  localparam logic [15:0] FetchRdy  = 16'hE600;
  localparam logic [15:0] FetchWait = 16'h2600;
  localparam logic [15:0] FetchErr  = 16'h2601;
  localparam logic [15:0] ExR       = 16'h0080;
  localparam logic [15:0] ExI       = 16'h0180;
  localparam logic [15:0] ExLs      = 16'h0100;
  localparam logic [15:0] ExBrTaken = 16'h8046;
  localparam logic [15:0] ExBrNot   = 16'h0046;
  localparam logic [15:0] ExJal     = 16'h8816;
  localparam logic [15:0] ExJalr    = 16'h891A;
  localparam logic [15:0] MemRd     = 16'h2000;
  localparam logic [15:0] MemRdErr  = 16'h2001;
  localparam logic [15:0] MemWr     = 16'h1000;
  localparam logic [15:0] MemWrDone = 16'h1002;
  localparam logic [15:0] WbR       = 16'h0802;
  localparam logic [15:0] WbLd      = 16'h0822;
`ifdef ILLEGAL_TRAP_EN
  localparam logic [15:0] DecBad    = 16'h0000;
`else
  localparam logic [15:0] DecBad    = 16'h0002;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, ir_write, mem_read, mem_write, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic       mem_to_reg, link, retire, mem_err;
`ifdef ILLEGAL_TRAP_EN
  logic       trap;
`endif
  logic [15:0] outs;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign outs = {pc_write, ir_write, mem_read, mem_write, reg_write, alu_src_a, alu_src_b,
                 alu_op, mem_to_reg, link, pc_src, retire, mem_err};

  mc_controller #(
    .MEM_TIMEOUT (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .ir_write   (ir_write),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .mem_to_reg (mem_to_reg),
    .link       (link),
    .pc_src     (pc_src),
    .retire     (retire),
`ifdef ILLEGAL_TRAP_EN
    .trap       (trap),
`endif
    .mem_err    (mem_err)
  );

  task automatic test_reset();
    reset = 1'b1;
    mem_ready = 1'b1;
    opcode = OpR;
    zero = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (outs !== Idle) begin
        errors++;
        $display("FAIL reset cycle %0d: outs=%h expected %h", i, outs, Idle);
      end
      @(posedge clk); #1;
    end
    reset = 1'b0;
  endtask

  task automatic test_add();
    logic [15:0] exp [4];
    exp = '{FetchRdy, Idle, ExR, WbR};
    opcode = OpR;
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (outs !== exp[i]) begin
        errors++;
        $display("FAIL add cycle %0d: outs=%h expected %h", i, outs, exp[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_i_alu();
    logic [15:0] exp [4];
    exp = '{FetchRdy, Idle, ExI, WbR};
    opcode = OpI;
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (outs !== exp[i]) begin
        errors++;
        $display("FAIL i_alu cycle %0d: outs=%h expected %h", i, outs, exp[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load();
    logic [15:0] exp [8];
    logic        rdy [8];
    exp = '{FetchRdy, Idle, ExLs, MemRd, MemRd, MemRd, MemRd, WbLd};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    opcode = OpLd;
    for (int i = 0; i < 8; i++) begin
      mem_ready = rdy[i];
      @(negedge clk);
      checks++;
      if (outs !== exp[i]) begin
        errors++;
        $display("FAIL load cycle %0d: outs=%h expected %h", i, outs, exp[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_store();
    logic [15:0] exp [5];
    logic        rdy [5];
    exp = '{FetchRdy, Idle, ExLs, MemWr, MemWrDone};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    opcode = OpSt;
    for (int i = 0; i < 5; i++) begin
      mem_ready = rdy[i];
      @(negedge clk);
      checks++;
      if (outs !== exp[i]) begin
        errors++;
        $display("FAIL store cycle %0d: outs=%h expected %h", i, outs, exp[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    logic [15:0] exp [3];
    opcode = OpBr;
    mem_ready = 1'b1;
    for (int z = 1; z >= 0; z--) begin
      zero = (z == 1);
      exp = '{FetchRdy, Idle, (z == 1) ? ExBrTaken : ExBrNot};
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        checks++;
        if (outs !== exp[i]) begin
          errors++;
          $display("FAIL branch zero=%0d cycle %0d: outs=%h expected %h", z, i, outs, exp[i]);
        end
        @(posedge clk); #1;
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_jumps();
    logic [15:0] exp [3];
    mem_ready = 1'b1;
    for (int j = 0; j < 2; j++) begin
      opcode = (j == 0) ? OpJl : OpJr;
      exp = '{FetchRdy, Idle, (j == 0) ? ExJal : ExJalr};
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        checks++;
        if (outs !== exp[i]) begin
          errors++;
          $display("FAIL jump%0d cycle %0d: outs=%h expected %h", j, i, outs, exp[i]);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  // 16 stalled fetch cycles: error on the last, then a fresh fetch with no error.
  task automatic test_fetch_timeout();
    logic [15:0] want;
    opcode = OpR;
    for (int i = 0; i < 17; i++) begin
      mem_ready = 1'b0;
      want = (i == 15) ? FetchErr : FetchWait;
      @(negedge clk);
      checks++;
      if (outs !== want) begin
        errors++;
        $display("FAIL fetch_timeout cycle %0d: outs=%h expected %h", i, outs, want);
      end
      @(posedge clk); #1;
    end
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'b1;
      want = (i == 0) ? FetchRdy : (i == 1) ? Idle : (i == 2) ? ExR : WbR;
      @(negedge clk);
      checks++;
      if (outs !== want) begin
        errors++;
        $display("FAIL fetch_recover cycle %0d: outs=%h expected %h", i, outs, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout_race();
    logic [15:0] want;
    opcode = OpR;
    for (int i = 0; i < 19; i++) begin
      mem_ready = (i >= 15);
      want = (i < 15) ? FetchWait : (i == 15) ? FetchRdy : (i == 16) ? Idle :
             (i == 17) ? ExR : WbR;
      @(negedge clk);
      checks++;
      if (outs !== want) begin
        errors++;
        $display("FAIL timeout_race cycle %0d: outs=%h expected %h", i, outs, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mem_timeout();
    logic [15:0] want;
    opcode = OpLd;
    for (int i = 0; i < 20; i++) begin
      mem_ready = (i < 3);
      want = (i == 0) ? FetchRdy : (i == 1) ? Idle : (i == 2) ? ExLs :
             (i < 18) ? MemRd : (i == 18) ? MemRdErr : FetchWait;
      @(negedge clk);
      checks++;
      if (outs !== want) begin
        errors++;
        $display("FAIL mem_timeout cycle %0d: outs=%h expected %h", i, outs, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal_opcode();
    logic [15:0] exp [2];
    exp = '{FetchRdy, DecBad};
    opcode = OpBad;
    mem_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (outs !== exp[i]) begin
        errors++;
        $display("FAIL illegal cycle %0d: outs=%h expected %h", i, outs, exp[i]);
      end
      @(posedge clk); #1;
    end
`ifdef ILLEGAL_TRAP_EN
    for (int i = 0; i < 3; i++) begin
      opcode = (i == 1) ? OpR : OpBad;
      @(negedge clk);
      checks++;
      if (outs !== Idle || trap !== 1'b1) begin
        errors++;
        $display("FAIL trap_sticky cycle %0d: outs=%h trap=%b expected %h trap=1",
                 i, outs, trap, Idle);
      end
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (outs !== Idle || trap !== 1'b0) begin
      errors++;
      $display("FAIL trap_reset: outs=%h trap=%b expected %h trap=0", outs, trap, Idle);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (outs !== FetchRdy || trap !== 1'b0) begin
      errors++;
      $display("FAIL trap_cleared: outs=%h trap=%b expected %h trap=0", outs, trap, FetchRdy);
    end
    @(posedge clk); #1;
    opcode = OpSt;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    @(posedge clk); #1;
    mem_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
`endif
  endtask

  task automatic test_reset_mid_store();
    logic [15:0] want;
    opcode = OpSt;
    for (int i = 0; i < 8; i++) begin
      reset = (i == 4) || (i == 5);
      mem_ready = (i < 3) || (i == 4) || (i == 5) || (i == 7);
      want = (i == 0) ? FetchRdy : (i == 1) ? Idle : (i == 2) ? ExLs : (i == 3) ? MemWr :
             (i < 6) ? Idle : (i == 6) ? FetchWait : FetchRdy;
      @(negedge clk);
      checks++;
      if (outs !== want) begin
        errors++;
        $display("FAIL reset_mid_store cycle %0d: outs=%h expected %h", i, outs, want);
      end
      @(posedge clk); #1;
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_i_alu();
    test_load();
    test_store();
    test_branch();
    test_jumps();
    test_fetch_timeout();
    test_timeout_race();
    test_mem_timeout();
    test_illegal_opcode();
    test_reset_mid_store();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
